action_scheduler: RTL

Converts one-cycle button strobes from the debouncers into an ordered stream of game actions (left, right, jump, slide) for the player-motion logic. It latches every strobe and shares the single action channel between the buttons with round-robin arbitration. A minimum spacing between accepted actions is enforced, and actions are buffered in a small FIFO behind a valid/ready handshake. It sits between the input debounce stage and the game state update logic.

---
 rtl/game_pkg.sv | 38 +++
 rtl/action_fifo.sv | 61 ++++++
 rtl/action_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game action types and the round-robin pick helper used by the
// action scheduler.
package game_pkg;

    typedef enum logic [1:0] {
        ACT_LEFT  = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_JUMP  = 2'd2,
        ACT_SLIDE = 2'd3
    } action_t;

    localparam int ACTION_W = 2;
    localparam int NUM_ACT  = 4;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_COOLDOWN = 1'b1
    } sched_state_t;

    // First set request at index >= ptr, wrapping around; ACT_LEFT when none.
    function automatic action_t rr_pick(input logic [NUM_ACT-1:0]  req,
                                        input logic [ACTION_W-1:0] ptr);
        action_t             pick;
        logic                found;
        logic [ACTION_W-1:0] idx;
        pick  = ACT_LEFT;
        found = 1'b0;
        for (int i = 0; i < NUM_ACT; i++) begin
            idx = ptr + ACTION_W'(i);
            if (!found && req[idx]) begin
                pick  = action_t'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/action_fifo.sv
// Small synchronous FIFO for game actions. Full/empty come from the
// registered occupancy, so a pop never frees room for a push in the same
// cycle, and a push into an empty FIFO shows up on dout one cycle later.
module action_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [1:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    output logic full,
    input  logic pop,
    output T     dout,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy and
        // pointers define which entries are meaningful, and leaving it out
        // of reset lets it map onto plain RAM/register-file cells.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/action_scheduler.sv
// Turns one-cycle button strobes into an ordered stream of game actions:
// latches strobes as pending bits, arbitrates them round-robin, spaces
// accepted actions by a cooldown, and queues them in a small FIFO behind a
// valid/ready handshake.
// Build option: define ACTION_SCHED_DROP_CNT_EN to enable the saturating
// merged-strobe counter on drop_count; otherwise drop_count is tied to 0.
module action_scheduler
    import game_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int COOLDOWN_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTN-1:0]  btn_pulse,
    output logic                act_valid,
    input  logic                act_ready,
    output logic [ACTION_W-1:0] act_code,
    output logic                overflow,
    output logic [7:0]          drop_count
);

    localparam int CD_W = (COOLDOWN_CYCLES > 2) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CD_W-1:0] CD_INIT =
        (COOLDOWN_CYCLES > 1) ? CD_W'(COOLDOWN_CYCLES - 2) : '0;

    logic [NUM_BTN-1:0]  pending_q;
    logic [NUM_BTN-1:0]  pending_d;
    logic [NUM_BTN-1:0]  grant_mask;
    logic [NUM_BTN-1:0]  merge;
    logic [ACTION_W-1:0] rr_ptr;
    sched_state_t        state_q;
    sched_state_t        state_d;
    logic [CD_W-1:0]     cd_cnt_q;
    logic [CD_W-1:0]     cd_cnt_d;
    logic                grant;
    action_t             grant_idx;
    logic                fifo_full;
    logic                fifo_empty;
    logic                act_pop;
    action_t             fifo_dout;

    // Arbitration looks only at the registered pending bits.
    assign grant_idx = rr_pick(pending_q, rr_ptr);
    assign grant     = (state_q == ST_IDLE) && (|pending_q) && !fifo_full;

    // Pending update: grant clears its bit, a same-cycle strobe re-sets it,
    // and a strobe on a bit that stays pending is a merge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        grant_mask = '0;
        if (grant) grant_mask = NUM_BTN'(1) << grant_idx;
        merge     = btn_pulse & pending_q & ~grant_mask;
        pending_d = (pending_q & ~grant_mask) | btn_pulse;
    end

    // Pending bits, round-robin pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            rr_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (grant) rr_ptr <= ACTION_W'(grant_idx) + 1'b1;
            if (|merge) overflow <= 1'b1;
        end
    end

    // Cooldown FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cd_cnt_q <= cd_cnt_d;
        end
    end

    // Cooldown FSM next state: a grant starts the spacing window, which
    // blocks further grants until the counter has run down to zero.
    always_comb begin
        state_d  = state_q;
        cd_cnt_d = cd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant && (COOLDOWN_CYCLES > 1)) begin
                    state_d  = ST_COOLDOWN;
                    cd_cnt_d = CD_INIT;
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt_q == '0) state_d = ST_IDLE;
                else                cd_cnt_d = cd_cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ACTION_SCHED_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Count cycles with at least one merged strobe, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if ((|merge) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'd0;
`endif

    action_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (action_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   (grant_idx),
        .full  (fifo_full),
        .pop   (act_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign act_valid = !fifo_empty;
    assign act_pop   = act_valid && act_ready;
    assign act_code  = act_valid ? ACTION_W'(fifo_dout) : '0;

endmodule
